// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - framed host word stream to the shared weight write bus; optional checksum word under WEIGHT_LOADER_CHECKSUM_EN
module weight_loader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [7:0] MAGIC      = 8'hA5,
  parameter int         LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] weight_wr_data,
  output logic [ADDR_WIDTH-1:0] weight_wr_addr,
  output logic                  weight_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           words_loaded
);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;
`endif

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  s_ready_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           words_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
`endif

  logic                  accept_d;
  logic                  last_beat_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;

  // Beat handshake, end-of-payload detect and the address of the current payload word
  always_comb begin
    accept_d    = s_valid & s_ready_q;
    last_beat_d = (cnt_q == len_q - LEN_WIDTH'(1));
    wr_addr_d   = base_q + ADDR_WIDTH'(cnt_q);
  end

  // Packet parser: all outputs are registered; s_ready drops only for the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      words_q   <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      s_ready_q <= 1'b1;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            if (s_data[31:24] == MAGIC) begin
              base_q  <= ADDR_WIDTH'(s_data[23:0]);
              busy_q  <= 1'b1;
              state_q <= S_LEN;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LEN: begin
          if (accept_d) begin
            len_q <= s_data[LEN_WIDTH-1:0];
            cnt_q <= '0;
            if (s_data[LEN_WIDTH-1:0] != '0) begin
              state_q <= S_DATA;
            end else begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              s_ready_q <= 1'b0;
`endif
            end
          end
        end
        S_DATA: begin
          if (accept_d) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= s_data;
            wr_addr_q <= wr_addr_d;
            words_q   <= words_q + 32'd1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            csum_q    <= csum_q + s_data;
`endif
            if (last_beat_d) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              s_ready_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
          end
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept_d) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= (s_data != csum_q);
            s_ready_q <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign weight_wr_data = wr_data_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_en   = wr_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - scoreboard bench for weight_loader (checksum cases follow WEIGHT_LOADER_CHECKSUM_EN)
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_loaded;

  weight_loader dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .weight_wr_data (weight_wr_data),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_en   (weight_wr_en),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .words_loaded   (words_loaded)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_wr[$];
  logic [1:0]  exp_done[$];
  int          exp_bad = 0;
  logic [31:0] payload[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes / completions whenever the DUT presents them
  logic [63:0] m_e;
  logic [1:0]  m_d;
  initial begin
    forever begin
      @(negedge clk);
      if (weight_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", weight_wr_addr, weight_wr_data);
        end else begin
          m_e = exp_wr.pop_front();
          chk("write_addr_data", {weight_wr_addr, weight_wr_data}, m_e);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          m_d = exp_done.pop_front();
          chk("done_err", 64'(err), 64'(m_d[1]));
          chk("done_with_last_write", 64'(weight_wr_en), 64'(m_d[0]));
        end
      end else if (err) begin
        checks++;
        if (exp_bad > 0) exp_bad--;
        else begin
          errors++;
          $display("FAIL unexpected_err: got err=1 expected 0");
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted
  task automatic send(input logic [31:0] w);
    int t = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] pkt_sum;

  task automatic packet(input logic [23:0] base, input int n, input logic [7:0] len_hi, input int gap);
    pkt_sum = '0;
    for (int k = 0; k < n; k++) begin
      exp_wr.push_back({32'(base) + 32'(k), payload[k]});
      pkt_sum = pkt_sum + payload[k];
    end
`ifndef WEIGHT_LOADER_CHECKSUM_EN
    exp_done.push_back({1'b0, n > 0});
`endif
    send({8'hA5, base});
    chk("busy_after_header", 64'(busy), 64'd1);
    send({len_hi, 24'(n)});
    for (int k = 0; k < n; k++) begin
      send(payload[k]);
      if (k == 0 && n > 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_no_write", 64'(weight_wr_en), 64'd0);
        end
      end
    end
  endtask

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  task automatic csum(input logic [31:0] w, input logic bad);
    exp_done.push_back({bad, 1'b0});
    send(w);
  endtask
`endif

  task automatic close_pkt();
    idle(3);
    chk("busy_after_packet", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle(3);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_wr_en", 64'(weight_wr_en), 64'd0);
    chk("rst_wr_data", 64'(weight_wr_data), 64'd0);
    chk("rst_wr_addr", 64'(weight_wr_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("s_ready_after_rst", 64'(s_ready), 64'd1);

    // base 0, three back-to-back words; length upper bits set and ignored
    payload[0] = 32'h11; payload[1] = 32'h22; payload[2] = 32'h33;
    packet(24'h000000, 3, 8'hFF, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h66, 1'b0);
`endif
    close_pkt();
    chk("words_after_pkt1", 64'(words_loaded), 64'd3);

    // base 432 with a 2-cycle valid gap between payload words
    payload[0] = 32'hCAFE0001; payload[1] = 32'hCAFE0002;
    packet(24'h0001B0, 2, 8'h00, 2);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h95FC0003, 1'b0);
`endif
    close_pkt();

    // bad magic: err pulse, no busy, then a normal packet
    exp_bad = 1;
    send(32'h5A000000);
    chk("busy_bad_magic", 64'(busy), 64'd0);
    idle(2);
    chk("bad_magic_err_seen", 64'(exp_bad), 64'd0);
    payload[0] = 32'h12345678;
    packet(24'h000010, 1, 8'h00, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h12345678, 1'b0);
`endif
    close_pkt();

    // zero length
    packet(24'h000040, 0, 8'h00, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h0, 1'b0);
`endif
    close_pkt();

    // wrapping payload sum: good checksum then bad checksum
    payload[0] = 32'hFFFFFFFF; payload[1] = 32'h00000002;
    packet(24'h000080, 2, 8'h00, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h00000001, 1'b0);
`endif
    close_pkt();
    packet(24'h000090, 2, 8'h00, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h00000005, 1'b1);
`endif
    close_pkt();
    chk("words_before_reset", 64'(words_loaded), 64'd10);

    // reset after 2 of 5 payload words
    exp_wr.push_back({32'h200, 32'hA0});
    exp_wr.push_back({32'h201, 32'hA1});
    send(32'hA5000200);
    send(32'd5);
    send(32'hA0);
    send(32'hA1);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_wr_en", 64'(weight_wr_en), 64'd0);
    idle(1);
    chk("mid_rst_s_ready2", 64'(s_ready), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_words", 64'(words_loaded), 64'd0);
    payload[0] = 32'hB0; payload[1] = 32'hB1;
    packet(24'h000300, 2, 8'h00, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum(32'h161, 1'b0);
`endif
    close_pkt();
    chk("words_after_reset_pkt", 64'(words_loaded), 64'd2);

    idle(3);
    chk("pending_writes", 64'(exp_wr.size()), 64'd0);
    chk("pending_dones", 64'(exp_done.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
